meter_countdown: RTL and testbench
==================================

METER_COUNTDOWN -- requirements
Module: meter_countdown

Interface
REQ-001 SHALL have parameter EDGES_PER_SEC, default 10, meaning the number of slowclk rising edges per one-second decrement (must be even, at least 2).
REQ-002 SHALL have port fastclk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port slowclk, input, 1 bit: divided square wave from the clock divider, treated as asynchronous.
REQ-005 SHALL have ports add_60, add_120, add_180 and add_300, each input, 1 bit: one-fastclk-cycle pulses that add 60, 120, 180 or 300 seconds.
REQ-006 SHALL have ports preset_10 and preset_205, each input, 1 bit: one-cycle pulses that load 10 or 205 seconds.
REQ-007 SHALL have port time_left, output, 14 bits: remaining seconds, binary, range 0..9999.
REQ-008 SHALL have port bcd, output, 16 bits: time_left as four BCD digits, thousands in bits [15:12].
REQ-009 SHALL have port display_on, output, 1 bit: 1 means the digits are lit; 0 means blanked.
REQ-010 SHALL have port expired, output, 1 bit: 1 while time_left == 0.

Function
REQ-011 SHALL pass slowclk through a 2-flop synchronizer and detect rising edges, giving a 1-cycle edge pulse with 3-cycle max latency from the slowclk transition.
REQ-012 SHALL count edge pulses modulo EDGES_PER_SEC in a phase counter; reaching EDGES_PER_SEC-1 with another edge pulse produces a 1-cycle sec_tick and wraps the counter to 0.
REQ-013 SHALL hold three states: EXPIRED (time_left == 0), LOW (1..179), and HIGH (180..9999). The state SHALL be a function of the registered time_left only.
REQ-014 SHALL compute next time_left as min(9999, time_left - dec + sum), where dec = 1 if sec_tick and time_left > 0 (else 0), and sum is the total of all add pulses asserted in that cycle (simultaneous adds accumulate).
REQ-015 SHALL NOT decrement below 0; a sec_tick at 0 leaves time_left at 0.
REQ-016 SHALL give presets priority over adds and sec_tick in the same cycle; if both presets are asserted, preset_205 wins.
REQ-017 SHALL reset the phase counter to 0 on any add or preset, so the first decrement occurs a full second later.
REQ-018 SHALL saturate to 9999: for example, 9950 + add_60 gives 9999.
REQ-019 SHALL drive display_on as follows:
- HIGH: constant 1.
- LOW: 1 while phase < EDGES_PER_SEC/2, otherwise 0 (1 Hz blink).
- EXPIRED: toggles on every EDGES_PER_SEC/2-th edge pulse (1 Hz blink of 0000).
REQ-020 SHALL update bcd exactly 1 fastclk cycle after time_left changes; expired SHALL be combinational from time_left.
REQ-021 SHALL use widths wide enough that the 14-bit arithmetic in REQ-014 never overflows (max intermediate 9999 + 660).

Reset
REQ-022 SHALL, on rst, immediately set: time_left = 0, bcd = 0, display_on = 1, expired = 1, phase = 0, synchronizer flops = 0, edge detector = 0.
REQ-023 SHALL, when rst deasserts, detect no spurious edge if slowclk is high; the first edge pulse requires a low-to-high transition seen after reset.
REQ-024 SHALL discard any in-flight add or preset pulse if rst is asserted in the middle of a countdown.

Structure
REQ-025 SHALL place MAX_TIME = 9999, LOW_THRESH = 180, PRESET_A = 10, PRESET_B = 205, the add amounts, and the state encoding in a shared package meter_pkg.
REQ-026 SHALL implement binary-to-BCD conversion in one sub-module, bin2bcd (14-bit in, 16-bit out, registered output, 1-cycle latency).

Verification
REQ-027 SHALL verify preset: with EDGES_PER_SEC=4, preset_10 then 40 slowclk rising edges -> time_left goes 10, 9, ... 0; expired rises after the 40th edge; display_on blinks.
REQ-028 SHALL verify saturation: preset_205 followed by 33 add_300 pulses -> time_left = 9999; bcd = 16'h9999; display_on constant 1.
REQ-029 SHALL verify simultaneous events: time_left = 181, sec_tick coincident with add_60 and add_120 -> time_left = 360; a sec_tick coincident with preset_10 -> time_left = 10.
REQ-030 SHALL verify LOW blink: time_left = 100, EDGES_PER_SEC=4 -> display_on = 1 for 2 edges, then 0 for 2 edges, repeating.
REQ-031 SHALL verify reset mid-countdown: at time_left = 500, assert rst asynchronously between clock edges -> outputs reach their reset values before the next fastclk edge; slowclk held high through the release of rst -> no decrement.
REQ-032 SHALL verify the zero floor: at time_left = 0, 8 edge pulses -> time_left stays 0; display_on toggles every 2 edges (with EDGES_PER_SEC = 4).

Source files
------------

// File: rtl/meter_pkg.sv
// meter_pkg: constants, state encoding and helpers shared by the parking-meter
// countdown and its binary-to-BCD converter.
package meter_pkg;

  localparam int TIME_W = 14;  // time_left width, 0..9999
  localparam int SUM_W  = 15;  // headroom for 9999 + 660 before saturation
  localparam int BCD_W  = 16;  // four BCD digits

  localparam int MAX_TIME   = 9999;
  localparam int LOW_THRESH = 180;
  localparam int PRESET_A   = 10;
  localparam int PRESET_B   = 205;
  localparam int ADD_A      = 60;
  localparam int ADD_B      = 120;
  localparam int ADD_C      = 180;
  localparam int ADD_D      = 300;

  typedef enum logic [1:0] {
    ST_EXPIRED = 2'd0,  // time_left == 0
    ST_LOW     = 2'd1,  // 1 .. LOW_THRESH-1
    ST_HIGH    = 2'd2   // LOW_THRESH .. MAX_TIME
  } meter_state_e;

  // The state is a pure decode of the registered remaining time.
  function automatic meter_state_e state_of(input logic [TIME_W-1:0] t);
    if (t == '0)                        return ST_EXPIRED;
    else if (t < TIME_W'(LOW_THRESH))   return ST_LOW;
    else                                return ST_HIGH;
  endfunction

endpackage

// File: rtl/meter_countdown_bin2bcd.sv
// bin2bcd: registered 14-bit binary to 4-digit BCD converter, 1-cycle latency.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset (clears output to 0)
//   bin_i  - binary value, 0..9999
//   bcd_o  - BCD digits, thousands in [15:12]
module bin2bcd
  import meter_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [TIME_W-1:0] bin_i,
  output logic [BCD_W-1:0]  bcd_o
);

  logic [BCD_W+TIME_W-1:0] shift;
  logic [BCD_W-1:0]        bcd_d;
  logic [BCD_W-1:0]        bcd_q;

  // Double dabble: before each shift, any digit >= 5 gets +3 so that the
  // shift carries correctly into the next decimal digit.
  always_comb begin
    shift = {{BCD_W{1'b0}}, bin_i};
    for (int i = 0; i < TIME_W; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (shift[TIME_W + 4*d +: 4] >= 4'd5)
          shift[TIME_W + 4*d +: 4] = shift[TIME_W + 4*d +: 4] + 4'd3;
      end
      shift = shift << 1;
    end
    bcd_d = shift[BCD_W+TIME_W-1:TIME_W];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bcd_q <= '0;
    else       bcd_q <= bcd_d;
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/meter_countdown.sv
// meter_countdown: parking-meter countdown timer.
// Ports:
//   fastclk            - system clock, all state changes on its rising edge
//   rst                - asynchronous active-high reset
//   slowclk            - asynchronous divided square wave, EDGES_PER_SEC rises/s
//   add_60..add_300    - 1-cycle pulses adding time (simultaneous adds sum)
//   preset_10/_205     - 1-cycle pulses loading time (205 wins, beats adds)
//   time_left          - remaining seconds, 0..9999
//   bcd                - time_left as BCD, one cycle behind time_left
//   display_on         - digit enable (steady, or 1 Hz blink when low/expired)
//   expired            - high while time_left == 0
module meter_countdown
  import meter_pkg::*;
#(
  parameter int EDGES_PER_SEC = 10  // even, >= 2
) (
  input  logic              fastclk,
  input  logic              rst,
  input  logic              slowclk,
  input  logic              add_60,
  input  logic              add_120,
  input  logic              add_180,
  input  logic              add_300,
  input  logic              preset_10,
  input  logic              preset_205,
  output logic [TIME_W-1:0] time_left,
  output logic [BCD_W-1:0]  bcd,
  output logic              display_on,
  output logic              expired
);

  localparam int PH_W = (EDGES_PER_SEC > 2) ? $clog2(EDGES_PER_SEC) : 1;
  localparam logic [PH_W-1:0]   PH_LAST      = PH_W'(EDGES_PER_SEC - 1);
  localparam logic [PH_W-1:0]   PH_HALF      = PH_W'(EDGES_PER_SEC / 2);
  localparam logic [PH_W-1:0]   PH_HALF_LAST = PH_W'(EDGES_PER_SEC / 2 - 1);
  localparam logic [SUM_W-1:0]  MAX_SUM      = SUM_W'(MAX_TIME);

  // Synchronizer, edge detector and start-up qualifier.
  logic       sync1_q, sync2_q, prev_q;
  logic [2:0] armed_q;
  logic       edge_pulse;
  logic       sec_tick;
  logic       any_load;

  logic [PH_W-1:0]   phase_q, phase_d;
  logic [TIME_W-1:0] time_left_q, time_left_d;
  logic              blink_q, blink_d;
  meter_state_e      state;

  logic [SUM_W-1:0]  add_sum;
  logic [SUM_W-1:0]  raw_sum;
  logic              dec;

  // armed_q fills with ones after reset; bit 2 is set only once prev_q holds a
  // real post-reset sample, so slowclk already high at release is not an edge.
  always_ff @(posedge fastclk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= '0;
    end else begin
      sync1_q <= slowclk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      armed_q <= {armed_q[1:0], 1'b1};
    end
  end

  assign edge_pulse = sync2_q & ~prev_q & armed_q[2];
  assign sec_tick   = edge_pulse && (phase_q == PH_LAST);
  assign any_load   = add_60 | add_120 | add_180 | add_300 | preset_10 | preset_205;
  assign state      = state_of(time_left_q);

  // State registers.
  always_ff @(posedge fastclk or posedge rst) begin
    if (rst) begin
      phase_q     <= '0;
      time_left_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      phase_q     <= phase_d;
      time_left_q <= time_left_d;
      blink_q     <= blink_d;
    end
  end

  // Next-state logic.
  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    phase_d     = phase_q;
    time_left_d = time_left_q;
    blink_d     = blink_q;

    add_sum = (add_60  ? SUM_W'(ADD_A) : '0)
            + (add_120 ? SUM_W'(ADD_B) : '0)
            + (add_180 ? SUM_W'(ADD_C) : '0)
            + (add_300 ? SUM_W'(ADD_D) : '0);
    dec     = sec_tick && (time_left_q != '0);
    // dec is only set when time_left > 0, so this never wraps below zero.
    raw_sum = {1'b0, time_left_q} + add_sum - SUM_W'(dec);

    // Any user action restarts the second so the next decrement is a full
    // second away.
    if (any_load)        phase_d = '0;
    else if (edge_pulse) phase_d = sec_tick ? '0 : phase_q + 1'b1;

    if (preset_205)          time_left_d = TIME_W'(PRESET_B);
    else if (preset_10)      time_left_d = TIME_W'(PRESET_A);
    else if (raw_sum > MAX_SUM) time_left_d = TIME_W'(MAX_TIME);
    else                     time_left_d = raw_sum[TIME_W-1:0];

    // Outside EXPIRED the blink is held lit so the 0000 display starts on.
    if (state != ST_EXPIRED)
      blink_d = 1'b1;
    else if (edge_pulse && (phase_q == PH_HALF_LAST || phase_q == PH_LAST))
      blink_d = ~blink_q;
  end

  // Output logic.
  always_comb begin
    display_on = 1'b1;
    case (state)
      ST_HIGH:    display_on = 1'b1;
      ST_LOW:     display_on = (phase_q < PH_HALF);
      ST_EXPIRED: display_on = blink_q;
      default:    display_on = 1'b1;
    endcase
  end

  assign time_left = time_left_q;
  assign expired   = (time_left_q == '0);

  bin2bcd u_bin2bcd (
    .clk_i (fastclk),
    .rst_i (rst),
    .bin_i (time_left_q),
    .bcd_o (bcd)
  );

endmodule

// File: tb/tb_meter_countdown.sv
module tb_meter_countdown;

  localparam int EPS = 4;

  logic        fastclk;
  logic        rst;
  logic        slowclk;
  logic        add_60, add_120, add_180, add_300, preset_10, preset_205;
  logic [13:0] time_left;
  logic [15:0] bcd;
  logic        display_on;
  logic        expired;

  int total = 0;
  int bad   = 0;

  meter_countdown #(.EDGES_PER_SEC(EPS)) dut (
    .fastclk    (fastclk),
    .rst        (rst),
    .slowclk    (slowclk),
    .add_60     (add_60),
    .add_120    (add_120),
    .add_180    (add_180),
    .add_300    (add_300),
    .preset_10  (preset_10),
    .preset_205 (preset_205),
    .time_left  (time_left),
    .bcd        (bcd),
    .display_on (display_on),
    .expired    (expired)
  );

  initial fastclk = 1'b0;
  always #5 fastclk = ~fastclk;

  // ctrl bit order: {preset_205, preset_10, add_300, add_180, add_120, add_60}
  localparam logic [5:0] C_A60  = 6'b000001;
  localparam logic [5:0] C_A120 = 6'b000010;
  localparam logic [5:0] C_A180 = 6'b000100;
  localparam logic [5:0] C_A300 = 6'b001000;
  localparam logic [5:0] C_P10  = 6'b010000;
  localparam logic [5:0] C_P205 = 6'b100000;

  typedef struct {
    string      name;
    logic [5:0] ctrl;
    int         tl;
  } vec_t;

  typedef struct {
    string name;
    int    tl;
    int    disp;  // -1: not checked
  } exp_t;

  exp_t sb[$];

  function automatic int to_bcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
           (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  task automatic set_ctrl(input logic [5:0] c);
    {preset_205, preset_10, add_300, add_180, add_120, add_60} = c;
  endtask

  task automatic push_exp(input string name, input int tl, input int disp);
    exp_t e;
    e.name = name;
    e.tl   = tl;
    e.disp = disp;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check({e.name, ".time_left"}, int'(time_left), e.tl);
    check({e.name, ".bcd"}, int'(bcd), to_bcd(e.tl));
    check({e.name, ".expired"}, int'(expired), (e.tl == 0) ? 1 : 0);
    if (e.disp >= 0) check({e.name, ".display_on"}, int'(display_on), e.disp);
  endtask

  // One-cycle control pulse; returns once bcd has caught up.
  task automatic pulse(input logic [5:0] c);
    @(negedge fastclk); set_ctrl(c);
    @(negedge fastclk); set_ctrl(6'b0);
    @(negedge fastclk);
  endtask

  // One full slowclk period (rise, then fall).
  task automatic slow_edge();
    @(negedge fastclk); slowclk = 1'b1;
    repeat (4) @(negedge fastclk);
    slowclk = 1'b0;
    repeat (3) @(negedge fastclk);
  endtask

  // Rising slowclk whose internal edge pulse lands in the same cycle as c.
  task automatic edge_with(input logic [5:0] c);
    @(negedge fastclk); slowclk = 1'b1;
    @(negedge fastclk);
    @(negedge fastclk); set_ctrl(c);
    @(negedge fastclk); set_ctrl(6'b0);
    @(negedge fastclk); slowclk = 1'b0;
    repeat (3) @(negedge fastclk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[9];
  int   prev_tl;
  int   tl;

  initial begin
    vecs[0] = '{"preset10",      C_P10,                           10};
    vecs[1] = '{"add60",         C_A60,                           70};
    vecs[2] = '{"add120_180",    C_A120 | C_A180,                 370};
    vecs[3] = '{"add300",        C_A300,                          670};
    vecs[4] = '{"all_adds",      C_A60 | C_A120 | C_A180 | C_A300, 1330};
    vecs[5] = '{"both_presets",  C_P10 | C_P205,                  205};
    vecs[6] = '{"preset_vs_add", C_P205 | C_A300,                 205};
    vecs[7] = '{"p10_vs_add",    C_P10 | C_A60,                   10};
    vecs[8] = '{"add180",        C_A180,                          190};

    rst = 1'b0; slowclk = 1'b0; set_ctrl(6'b0);
    #1 rst = 1'b1;
    #2;
    check("rst_async.time_left", int'(time_left), 0);
    check("rst_async.bcd", int'(bcd), 0);
    check("rst_async.display_on", int'(display_on), 1);
    check("rst_async.expired", int'(expired), 1);
    repeat (3) @(negedge fastclk);
    rst = 1'b0;
    repeat (4) @(negedge fastclk);
    push_exp("reset", 0, 1);
    compare_out();

    // Single-cycle control vectors, including bcd lagging by one cycle.
    prev_tl = 0;
    foreach (vecs[i]) begin
      push_exp(vecs[i].name, vecs[i].tl, 1);
      @(negedge fastclk); set_ctrl(vecs[i].ctrl);
      @(negedge fastclk); set_ctrl(6'b0);
      check({vecs[i].name, ".bcd_lag"}, int'(bcd), to_bcd(prev_tl));
      @(negedge fastclk);
      compare_out();
      prev_tl = vecs[i].tl;
    end

    // Simultaneous events: 190 -> 181, then tick + adds, then tick + preset.
    repeat (36) slow_edge();
    push_exp("at181", 181, 1); compare_out();
    repeat (3) slow_edge();
    push_exp("tick_plus_adds", 360, 1);
    edge_with(C_A60 | C_A120);
    compare_out();
    repeat (3) slow_edge();
    push_exp("tick_plus_preset", 10, 1);
    edge_with(C_P10);
    compare_out();
    repeat (3) slow_edge();
    push_exp("full_sec_after_preset", 10, 0); compare_out();
    slow_edge();
    push_exp("first_dec_after_preset", 9, 1); compare_out();

    // Preset 10 then 40 edges down to zero, then 8 edges at the floor.
    pulse(C_P10);
    for (int k = 1; k <= 40; k++) begin
      tl = 10 - k / EPS;
      push_exp($sformatf("countdown_e%0d", k), tl,
               (tl == 0) ? 1 : (((k % EPS) < EPS / 2) ? 1 : 0));
      slow_edge();
      compare_out();
    end
    for (int k = 1; k <= 8; k++) begin
      push_exp($sformatf("floor_e%0d", k), 0, ((k % 4) < 2) ? 1 : 0);
      slow_edge();
      compare_out();
    end

    // LOW blink at 100.
    pulse(C_P10);
    pulse(C_A120);
    repeat (120) slow_edge();
    push_exp("at100", 100, 1); compare_out();
    for (int k = 1; k <= 8; k++) begin
      push_exp($sformatf("low_blink_e%0d", k), 100 - k / EPS,
               ((k % EPS) < EPS / 2) ? 1 : 0);
      slow_edge();
      compare_out();
    end

    // Saturation.
    pulse(C_P205);
    for (int k = 1; k <= 33; k++) pulse(C_A300);
    push_exp("saturate", 9999, 1); compare_out();
    for (int k = 1; k <= 4; k++) begin
      push_exp($sformatf("high_steady_e%0d", k), (k == 4) ? 9998 : 9999, 1);
      slow_edge();
      compare_out();
    end

    // Reset mid-countdown with slowclk high across release.
    pulse(C_P205);
    pulse(C_A300);
    repeat (20) slow_edge();
    push_exp("at500", 500, 1); compare_out();
    @(negedge fastclk); slowclk = 1'b1;
    repeat (4) @(negedge fastclk);
    @(posedge fastclk);
    #2 rst = 1'b1; add_60 = 1'b1;
    #1;
    check("rst_mid.time_left", int'(time_left), 0);
    check("rst_mid.bcd", int'(bcd), 0);
    check("rst_mid.display_on", int'(display_on), 1);
    check("rst_mid.expired", int'(expired), 1);
    @(negedge fastclk); add_60 = 1'b0;
    repeat (2) @(negedge fastclk);
    rst = 1'b0;
    repeat (6) @(negedge fastclk);
    push_exp("post_rst", 0, 1); compare_out();
    @(negedge fastclk); slowclk = 1'b0;
    repeat (3) @(negedge fastclk);
    push_exp("post_rst_e1", 0, 1);
    slow_edge();
    compare_out();
    push_exp("post_rst_e2", 0, 0);
    slow_edge();
    compare_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
